// File: rtl/dlldel_adj_scheduler.sv
// dlldel_adj_scheduler
//   Sequences and shares delay-code adjustment across NCH DLLDEL_CORE instances.
//   Once DDRDLL lock has been stable for LOCK_WAIT cycles, every DLLDEL code is
//   reloaded by pulling LOAD_N low for LOAD_CYC cycles. After that, per-channel
//   step requests are granted round-robin. Each granted request sets DIR, then
//   issues single-cycle MOVE pulses, each followed by GAP_CYC low cycles.
//
// Ports
//   clk, rst_n        fabric clock, synchronous active-low reset
//   dll_lock          DDRDLL LOCK; losing it aborts and forces a full reload
//   req_valid/dir     per-channel request valid and direction (1 = more delay)
//   req_steps         per-channel step count, slice [i*SW +: SW]
//   req_ready         one-cycle accept pulse for the granted channel
//   done, err         one-cycle completion pulse; err marks an aborted request
//   busy              low only while idle and waiting for requests
//   dl_load_n/move/dir  to the DLLDEL_CORE pins
//   dl_cflag          DLLDEL CFLAG (code at limit)
//
// Configuration
//   DLLDEL_SCHED_CFLAG_EN: when defined, CFLAG is sampled during the gap and a
//   high flag drops the remaining steps and ends the request with err = 1.
//   When undefined, CFLAG is ignored.
module dlldel_adj_scheduler #(
    parameter int NCH       = 4,
    parameter int SW        = 8,
    parameter int LOCK_WAIT = 16,
    parameter int LOAD_CYC  = 4,
    parameter int GAP_CYC   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dll_lock,
    input  logic [NCH-1:0]      req_valid,
    input  logic [NCH-1:0]      req_dir,
    input  logic [NCH*SW-1:0]   req_steps,
    output logic [NCH-1:0]      req_ready,
    output logic [NCH-1:0]      done,
    output logic                err,
    output logic                busy,
    output logic [NCH-1:0]      dl_load_n,
    output logic [NCH-1:0]      dl_move,
    output logic [NCH-1:0]      dl_dir,
    input  logic [NCH-1:0]      dl_cflag
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = 16;

    typedef enum logic [2:0] {
        S_WAIT_LOCK, S_LOAD, S_IDLE, S_SETUP, S_MOVE, S_GAP, S_DONE
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [IW-1:0]  rr;
    logic [IW-1:0]  gnt;
    logic           dir_lat;
    logic [SW-1:0]  steps;
    logic [NCH-1:0] gsel;

    logic           found;
    logic [IW-1:0]  pick;
    logic [IW-1:0]  rr_next;
    logic           pick_dir;
    logic [SW-1:0]  pick_steps;
    logic [IW:0]    idx;

    assign gsel = NCH'(1) << gnt;

    // Round-robin search: first valid request at or after rr, wrapping.
    always_comb begin
        found      = 1'b0;
        pick       = '0;
        idx        = '0;
        pick_dir   = 1'b0;
        pick_steps = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = {1'b0, rr} + (IW+1)'(k);
            if (idx >= (IW+1)'(NCH))
                idx = idx - (IW+1)'(NCH);
            if (!found && req_valid[idx[IW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IW-1:0];
            end
        end
        for (int k = 0; k < NCH; k++) begin
            if (IW'(k) == pick) begin
                pick_dir   = req_dir[k];
                pick_steps = req_steps[k*SW +: SW];
            end
        end
        rr_next = (pick == IW'(NCH-1)) ? '0 : pick + 1'b1;
    end

`ifdef DLLDEL_SCHED_CFLAG_EN
    logic err_pend;
`else
    logic unused_cflag;
    assign unused_cflag = ^dl_cflag;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_WAIT_LOCK;
            cnt       <= '0;
            rr        <= '0;
            gnt       <= '0;
            dir_lat   <= 1'b0;
            steps     <= '0;
            req_ready <= '0;
            done      <= '0;
            err       <= 1'b0;
            busy      <= 1'b1;
            dl_load_n <= '1;
            dl_move   <= '0;
            dl_dir    <= '0;
`ifdef DLLDEL_SCHED_CFLAG_EN
            err_pend  <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low every cycle.
            req_ready <= '0;
            done      <= '0;
            err       <= 1'b0;
            dl_move   <= '0;
            if (state != S_WAIT_LOCK && !dll_lock) begin
                // Lock lost: abort any in-flight request and start over with a reload.
                if (state == S_SETUP || state == S_MOVE || state == S_GAP || state == S_DONE) begin
                    done <= gsel;
                    err  <= 1'b1;
                end
                state     <= S_WAIT_LOCK;
                cnt       <= '0;
                dl_load_n <= '1;
                busy      <= 1'b1;
            end else begin
                case (state)
                    S_WAIT_LOCK: begin
                        busy <= 1'b1;
                        if (!dll_lock) begin
                            cnt <= '0;
                        end else if (cnt == CW'(LOCK_WAIT-1)) begin
                            cnt       <= '0;
                            dl_load_n <= '0;
                            state     <= S_LOAD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_LOAD: begin
                        if (cnt == CW'(LOAD_CYC-1)) begin
                            cnt       <= '0;
                            dl_load_n <= '1;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_IDLE: begin
                        if (found) begin
                            req_ready <= NCH'(1) << pick;
                            gnt       <= pick;
                            dir_lat   <= pick_dir;
                            steps     <= pick_steps;
                            rr        <= rr_next;
                            busy      <= 1'b1;
`ifdef DLLDEL_SCHED_CFLAG_EN
                            err_pend  <= 1'b0;
`endif
                            // Zero-step requests complete without touching DIR/MOVE.
                            state     <= (pick_steps == '0) ? S_DONE : S_SETUP;
                        end
                    end
                    S_SETUP: begin
                        // Only the granted channel's DIR changes; others keep their last value.
                        dl_dir <= (dl_dir & ~gsel) | (dir_lat ? gsel : '0);
                        state  <= S_MOVE;
                    end
                    S_MOVE: begin
                        dl_move <= gsel;
                        steps   <= steps - 1'b1;
                        cnt     <= '0;
                        state   <= S_GAP;
                    end
                    S_GAP: begin
`ifdef DLLDEL_SCHED_CFLAG_EN
                        if (|(dl_cflag & gsel)) begin
                            err_pend <= 1'b1;
                            cnt      <= '0;
                            state    <= S_DONE;
                        end else
`endif
                        if (cnt == CW'(GAP_CYC-1)) begin
                            cnt   <= '0;
                            state <= (steps != '0) ? S_MOVE : S_DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        done  <= gsel;
`ifdef DLLDEL_SCHED_CFLAG_EN
                        err   <= err_pend;
`else
                        err   <= 1'b0;
`endif
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_WAIT_LOCK;
                endcase
            end
        end
    end

endmodule
